fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end of core_lapido: owns the program counter, issues requests to instruction memory through a req/ready handshake, and presents fetched instructions with their next-PC to the IF/ID register. It is the receiving end of the MEM stage's branch-redirect interface: `branch_taken`/`branch_addr` from the branch resolution unit squash in-flight work and reload the PC. A one-entry skid buffer absorbs a memory response that arrives while the decode side is stalled.

## Interface
- `PC_WIDTH`, 32: width of PC and addresses; instantiated with `` `PC_WIDTH `` from lapido_defs.v.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_STEP`, 1: PC increment per instruction (word-addressed).

- `clk` in 1: the only clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `branch_taken` in 1: redirect request from the MEM stage; valid every cycle.
- `branch_addr` in PC_WIDTH: redirect target; sampled only when `branch_taken`=1.
- `stall` in 1: decode side cannot accept a new instruction this cycle.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out PC_WIDTH: fetch address; equals current PC.
- `imem_ready` in 1: memory completes the request this cycle; `imem_data` valid.
- `imem_data` in 32: instruction word.
- `out_valid` out 1: `out_instr`/`out_next_pc` hold a live instruction.
- `out_instr` out 32: fetched instruction.
- `out_next_pc` out PC_WIDTH: fetch address + PC_STEP (modulo 2^PC_WIDTH).

## Operation
- States: BOOT, FETCH, HOLD, DRAIN. Reset enters BOOT.
- `imem_req` = 1 in FETCH and DRAIN, 0 in BOOT and HOLD. `imem_addr` = PC in all states.
- Handshake: a request completes in the cycle `imem_req`=1 and `imem_ready`=1. While `imem_req`=1 and `imem_ready`=0, `imem_addr` must not change; the PC therefore never changes with a request outstanding.
- Output slot "can accept" = `out_valid`=0 or `stall`=0. Output holds its value when `stall`=1 and `out_valid`=1.
- BOOT → FETCH unconditionally (one cycle, no request).
- FETCH, no branch, completion, slot can accept: output ← (`imem_data`, PC+PC_STEP), `out_valid`←1, PC←PC+PC_STEP, stay FETCH.
- FETCH, no branch, completion, slot full: skid ← (`imem_data`, PC+PC_STEP), PC←PC+PC_STEP, go HOLD.
- FETCH, no completion, no branch: if `stall`=0, `out_valid`←0 (instruction consumed); stay FETCH.
- HOLD, no branch: when `stall`=0, output ← skid, `out_valid`←1, go FETCH; else hold.
- Branch (`branch_taken`=1) has priority over stall and over completion, in any state except BOOT:
  - `out_valid`←0, skid discarded, PC←`branch_addr`.
  - In FETCH with `imem_ready`=0 (request outstanding): PC load deferred; latch `branch_addr` into a pending-target register, go DRAIN.
  - In FETCH with `imem_ready`=1, or in HOLD: returned data dropped, PC←`branch_addr`, go FETCH.
- DRAIN: keep requesting old address; on `imem_ready`=1 drop data, PC←pending target, go FETCH. A further `branch_taken` in DRAIN overwrites the pending target.
- PC arithmetic wraps modulo 2^PC_WIDTH; no overflow flag.

## Timing
- Reset values (async, immediate): state BOOT, PC=RESET_PC, `imem_req`=0, `out_valid`=0, `out_instr`=0, `out_next_pc`=0, skid empty, pending target 0.
- First request: cycle after reset release is BOOT; `imem_req`=1 with `imem_addr`=RESET_PC the following cycle.
- Fetch latency: instruction appears on `out_*` one cycle after its completion cycle.
- Zero-wait memory (`imem_ready` tied 1), no stall: one instruction per cycle, sequential addresses.
- Redirect: first request to `branch_addr` issued the cycle after `branch_taken` (FETCH with ready, or HOLD), or the cycle after the drained completion (DRAIN). `out_valid`=0 the cycle after `branch_taken`.
- `rst` mid-request: abandons the request; memory must tolerate a dropped request.

## Test plan
- Reset, `imem_ready`=1, `imem_data`=0x1000_0000+addr, `stall`=0 → `imem_addr` 0,1,2,…; `out_instr` 0x1000_0000,0x1000_0001 one cycle later; `out_next_pc`=1,2,….
- `stall` high 3 cycles with `out_valid`=1 → output frozen, one word to skid, `imem_req`=0 during HOLD; on release skid emerges, no instruction lost or duplicated.
- `imem_ready`=0 for 4 cycles at addr 5 → `imem_addr` stays 5, `out_valid` drops once consumed; completion yields instr at addr 5 exactly once.
- `branch_taken`=1, `branch_addr`=0x40 with `imem_ready`=1 → `out_valid`=0 next cycle, next `imem_addr`=0x40, then output instr from 0x40 with `out_next_pc`=0x41.
- `branch_taken` to 0x80 while request at addr 7 stalls on ready=0 for 3 cycles, second branch to 0x90 during DRAIN → addr 7 held, its data dropped, next fetch at 0x90.
- `rst` asserted in HOLD with `stall`=1 → all outputs reset immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues imem requests, presents instr + next-PC to IF/ID.
// The output is registered one cycle after completion; a one-entry skid absorbs a response while decode stalls.
module fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = {{(PC_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_addr,
  input  logic                stall,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_data,
  output logic                out_valid,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_next_pc
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_npc_q, skid_npc_d;
  logic                out_valid_d;
  logic [31:0]         out_instr_d;
  logic [PC_WIDTH-1:0] out_next_pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                can_accept;

  assign pc_inc     = pc_q + PC_STEP;
  assign can_accept = !out_valid || !stall;
  assign imem_req   = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr  = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    skid_instr_d  = skid_instr_q;
    skid_npc_d    = skid_npc_q;
    out_valid_d   = out_valid;
    out_instr_d   = out_instr;
    out_next_pc_d = out_next_pc;

    unique case (state_q)
      BOOT: state_d = FETCH;

      FETCH: begin
        if (branch_taken) begin
          out_valid_d = 1'b0;
          // An outstanding request must finish at its old address before the PC may move.
          if (imem_ready) begin
            pc_d = branch_addr;
          end else begin
            pend_d  = branch_addr;
            state_d = DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (can_accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = imem_data;
            out_next_pc_d = pc_inc;
          end else begin
            skid_instr_d = imem_data;
            skid_npc_d   = pc_inc;
            state_d      = HOLD;
          end
        end else if (!stall) begin
          out_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          out_valid_d = 1'b0;
          pc_d        = branch_addr;
          state_d     = FETCH;
        end else if (!stall) begin
          out_valid_d   = 1'b1;
          out_instr_d   = skid_instr_q;
          out_next_pc_d = skid_npc_q;
          state_d       = FETCH;
        end
      end

      DRAIN: begin
        out_valid_d = 1'b0;
        if (branch_taken) pend_d = branch_addr;
        if (imem_ready) begin
          pc_d    = branch_taken ? branch_addr : pend_q;
          state_d = FETCH;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      skid_instr_q <= '0;
      skid_npc_q   <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_next_pc  <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
      out_valid    <= out_valid_d;
      out_instr    <= out_instr_d;
      out_next_pc  <= out_next_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against an in-order instruction-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_next_pc;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  always #5 clk = ~clk;

  // Memory returns a word derived from its address so every instruction is traceable.
  assign imem_data = 32'h1000_0000 + imem_addr;

  fetch_unit #(.PC_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_next_pc (out_next_pc)
  );

  task automatic do_reset();
    rst          = 1'b1;
    branch_taken = 1'b0;
    branch_addr  = '0;
    stall        = 1'b0;
    imem_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [97:0] got, exp;
    do_reset();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++;
    if (got !== exp) $display("FAIL reset_async: got %h want %h", got, exp); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    checks++;
    if (got !== exp) $display("FAIL reset_boot: got %h want %h", got, exp); else passed++;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++;
    if (got !== exp) $display("FAIL reset_first_req: got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_sequential();
    logic [97:0] got, exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
      if (i == 0) exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
      else        exp = {1'b1, 32'(i), 1'b1, 32'h1000_0000 + 32'(i - 1), 32'(i)};
      checks++;
      if (got !== exp) $display("FAIL sequential[%0d]: got %h want %h", i, got, exp); else passed++;
    end
  endtask

  task automatic test_stall_skid();
    logic [97:0] got, exp;
    do_reset();
    repeat (4) @(negedge clk);
    stall = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
      exp = {1'b0, 32'd4, 1'b1, 32'h1000_0002, 32'd3};
      checks++;
      if (got !== exp) $display("FAIL stall_hold[%0d]: got %h want %h", s, got, exp); else passed++;
    end
    stall = 1'b0;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'd4, 1'b1, 32'h1000_0003, 32'd4};
    checks++;
    if (got !== exp) $display("FAIL skid_release: got %h want %h", got, exp); else passed++;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'd5, 1'b1, 32'h1000_0004, 32'd5};
    checks++;
    if (got !== exp) $display("FAIL skid_after: got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_wait_states();
    logic [33:0] got_s, exp_s;
    logic [97:0] got, exp;
    do_reset();
    repeat (6) @(negedge clk);
    imem_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      got_s = {imem_req, imem_addr, out_valid};
      exp_s = {1'b1, 32'd5, 1'b0};
      checks++;
      if (got_s !== exp_s) $display("FAIL wait_hold[%0d]: got %h want %h", w, got_s, exp_s); else passed++;
    end
    imem_ready = 1'b1;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'd6, 1'b1, 32'h1000_0005, 32'd6};
    checks++;
    if (got !== exp) $display("FAIL wait_complete: got %h want %h", got, exp); else passed++;
    imem_ready = 1'b0;
    @(negedge clk);
    got_s = {imem_req, imem_addr, out_valid};
    exp_s = {1'b1, 32'd6, 1'b0};
    checks++;
    if (got_s !== exp_s) $display("FAIL wait_once: got %h want %h", got_s, exp_s); else passed++;
    imem_ready = 1'b1;
  endtask

  task automatic test_branch_ready();
    logic [33:0] got_s, exp_s;
    logic [97:0] got, exp;
    do_reset();
    repeat (4) @(negedge clk);
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    got_s = {imem_req, imem_addr, out_valid};
    exp_s = {1'b1, 32'h40, 1'b0};
    checks++;
    if (got_s !== exp_s) $display("FAIL branch_redirect: got %h want %h", got_s, exp_s); else passed++;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'h41, 1'b1, 32'h1000_0040, 32'h41};
    checks++;
    if (got !== exp) $display("FAIL branch_target_out: got %h want %h", got, exp); else passed++;
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFF;
    @(negedge clk);
    branch_taken = 1'b0;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'h0, 1'b1, 32'h0FFF_FFFF, 32'h0};
    checks++;
    if (got !== exp) $display("FAIL pc_wrap: got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_branch_drain();
    logic [33:0] got_s, exp_s;
    logic [97:0] got, exp;
    do_reset();
    repeat (8) @(negedge clk);
    imem_ready = 1'b0;
    exp_s = {1'b1, 32'd7, 1'b0};
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      branch_taken = 1'b0;
      got_s = {imem_req, imem_addr, out_valid};
      checks++;
      if (got_s !== exp_s) $display("FAIL drain_hold[%0d]: got %h want %h", d, got_s, exp_s); else passed++;
      if (d == 0) begin branch_taken = 1'b1; branch_addr = 32'h80; end
      if (d == 2) begin branch_taken = 1'b1; branch_addr = 32'h90; end
    end
    imem_ready = 1'b1;
    @(negedge clk);
    got_s = {imem_req, imem_addr, out_valid};
    exp_s = {1'b1, 32'h90, 1'b0};
    checks++;
    if (got_s !== exp_s) $display("FAIL drain_redirect: got %h want %h", got_s, exp_s); else passed++;
    @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'h91, 1'b1, 32'h1000_0090, 32'h91};
    checks++;
    if (got !== exp) $display("FAIL drain_target_out: got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_reset_in_hold();
    logic [33:0] got_s, exp_s;
    logic [97:0] got, exp;
    do_reset();
    repeat (4) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    got_s = {imem_req, imem_addr, out_valid};
    exp_s = {1'b0, 32'd4, 1'b1};
    checks++;
    if (got_s !== exp_s) $display("FAIL hold_entry: got %h want %h", got_s, exp_s); else passed++;
    #2 rst = 1'b1;
    #1;
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = '0;
    checks++;
    if (got !== exp) $display("FAIL hold_reset: got %h want %h", got, exp); else passed++;
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    got = {imem_req, imem_addr, out_valid, out_instr, out_next_pc};
    exp = {1'b1, 32'd1, 1'b1, 32'h1000_0000, 32'd1};
    checks++;
    if (got !== exp) $display("FAIL hold_restart: got %h want %h", got, exp); else passed++;
  endtask

  // Model: the in-order list of delivered-but-unconsumed instructions, the next address
  // to fetch, and whether an old-address completion is still owed before the redirect lands.
  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] exp_addr = '0;
    logic [31:0] held     = '0;
    bit          drop     = 1'b0;
    bit          req_m, br, rdy, st;
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      checks++;
      if (out_valid !== (q.size() > 0))
        $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, q.size() > 0);
      else passed++;
      if (q.size() > 0) begin
        checks++;
        if ({out_instr, out_next_pc} !== q[0])
          $display("FAIL rnd_out[%0d]: got %h want %h", c, {out_instr, out_next_pc}, q[0]);
        else passed++;
      end
      req_m = (q.size() != 2);
      checks++;
      if (imem_req !== req_m) $display("FAIL rnd_req[%0d]: got %b want %b", c, imem_req, req_m);
      else passed++;
      checks++;
      if (imem_addr !== (drop ? held : exp_addr))
        $display("FAIL rnd_addr[%0d]: got %h want %h", c, imem_addr, drop ? held : exp_addr);
      else passed++;

      st  = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < 6);
      br  = ($urandom_range(0, 15) == 0) && !(drop && rdy);
      stall        = st;
      imem_ready   = rdy;
      branch_taken = br;
      branch_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;

      if (br) begin
        q.delete();
        if (!drop && req_m && !rdy) begin
          drop = 1'b1;
          held = exp_addr;
        end
        exp_addr = branch_addr;
      end else if (drop) begin
        if (rdy) drop = 1'b0;
      end else begin
        if (q.size() > 0 && !st) void'(q.pop_front());
        if (req_m && rdy) begin
          e.instr = 32'h1000_0000 + exp_addr;
          e.npc   = exp_addr + 32'd1;
          q.push_back(e);
          exp_addr = exp_addr + 32'd1;
        end
      end
      @(negedge clk);
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    imem_ready   = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    branch_taken = 1'b0;
    branch_addr  = '0;
    stall        = 1'b0;
    imem_ready   = 1'b1;
    test_reset();
    test_sequential();
    test_stall_skid();
    test_wait_states();
    test_branch_ready();
    test_branch_drain();
    test_reset_in_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
